// File: rtl/ctr_pkg.sv
// Shared constants and feeder state encoding for the AES-256-CTR path.
package ctr_pkg;

  localparam int AES_BLK_W    = 128;
  localparam int AES_KEY_W    = 256;
  localparam int CTR_DATA_W   = 1024;
  localparam int CTR_MAX_BLKS = CTR_DATA_W / AES_BLK_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } feeder_state_e;

endpackage

// File: rtl/ctr_inc.sv
// Combinational W-bit counter incrementer; all ones wraps to zero silently.
module ctr_inc #(
  parameter int W = 128
) (
  input  logic [W-1:0] i_ctr,
  output logic [W-1:0] o_ctr
);

  assign o_ctr = i_ctr + W'(1);

endmodule

// File: rtl/ctr_block_feeder.sv
// Captures a message plus IV and issues (block, IV+i) pairs over valid/ready.
module ctr_block_feeder
  import ctr_pkg::*;
#(
  parameter int DATA_W   = CTR_DATA_W,
  parameter int BLK_W    = AES_BLK_W,
  parameter int MAX_BLKS = DATA_W / BLK_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] plaintext_in,
  input  logic [BLK_W-1:0]  iv,
  input  logic [3:0]        num_blocks,
  output logic              busy,
  output logic              blk_valid,
  input  logic              blk_ready,
  output logic [BLK_W-1:0]  blk_ctr,
  output logic [BLK_W-1:0]  blk_data,
  output logic [2:0]        blk_idx,
  output logic              blk_last,
  output logic              done,
  output feeder_state_e     dbg_state
);

  // Handshake: a block moves when blk_valid & blk_ready at a rising edge.
  // blk_valid comes from state alone, and all blk_* hold until that transfer.

  localparam logic [3:0] MAX_N = 4'(MAX_BLKS);

  feeder_state_e      r_state;
  feeder_state_e      w_next_state;
  logic [DATA_W-1:0]  r_data;
  logic [BLK_W-1:0]   r_ctr;
  logic [BLK_W-1:0]   r_blk_data;
  logic [2:0]         r_idx;
  logic [3:0]         r_n;

  logic [3:0]         w_n_eff;
  logic               w_capture;
  logic               w_xfer;
  logic               w_last;
  logic [2:0]         w_idx_inc;
  logic [BLK_W-1:0]   w_ctr_inc;
  logic [BLK_W-1:0]   w_blocks [MAX_BLKS];

  // Block 0 lives in the most significant slice of the message.
  for (genvar g = 0; g < MAX_BLKS; g++) begin : g_blk
    assign w_blocks[g] = r_data[DATA_W-1-g*BLK_W -: BLK_W];
  end

  assign w_n_eff   = (num_blocks > MAX_N) ? MAX_N : num_blocks;
  assign w_capture = (r_state == IDLE) && start;
  assign w_xfer    = (r_state == ISSUE) && blk_ready;
  assign w_last    = ({1'b0, r_idx} == (r_n - 4'd1));
  assign w_idx_inc = r_idx + 3'd1;

  ctr_inc #(.W(BLK_W)) u_ctr_inc (
    .i_ctr (r_ctr),
    .o_ctr (w_ctr_inc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start) w_next_state = (w_n_eff == 4'd0) ? DONE : ISSUE;
      ISSUE:   if (blk_ready && w_last) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    blk_valid = 1'b0;
    blk_last  = 1'b0;
    done      = 1'b0;
    case (r_state)
      ISSUE: begin
        busy      = 1'b1;
        blk_valid = 1'b1;
        blk_last  = w_last;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // The next block is preselected into r_blk_data so blk_data is a flop output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data     <= '0;
      r_ctr      <= '0;
      r_blk_data <= '0;
      r_idx      <= '0;
      r_n        <= '0;
    end else if (w_capture) begin
      r_data     <= plaintext_in;
      r_ctr      <= iv;
      r_blk_data <= plaintext_in[DATA_W-1 -: BLK_W];
      r_idx      <= '0;
      r_n        <= w_n_eff;
    end else if (w_xfer && !w_last) begin
      r_idx      <= w_idx_inc;
      r_ctr      <= w_ctr_inc;
      r_blk_data <= w_blocks[w_idx_inc];
    end
  end

  assign blk_ctr   = r_ctr;
  assign blk_data  = r_blk_data;
  assign blk_idx   = r_idx;
  assign dbg_state = r_state;

endmodule
